spi_tx_arbiter: RTL and testbench

// - Shares one 12-bit SPI transmit master among NREQ requesters.
// - Selects requesters round-robin and captures the winner's word.
// - Drives the master's newd/din and tracks the transfer through the master's cs.
// - Releases the next request only after the frame and an inter-frame gap complete.
// - Sits between client logic and the SPI master; both run on the same clk/rst.

---
 rtl/spi_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter that feeds words from NREQ clients into one SPI transmit master.
// Each frame runs through launch, transfer and an inter-frame gap before the next grant.
module spi_tx_arbiter #(
    parameter  int NREQ           = 4,
    parameter  int DW             = 12,
    parameter  int GAP_CYCLES     = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IW             = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 spi_newd,
    output logic [DW-1:0]        spi_din,
    input  logic                 spi_cs,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 done,
    output logic                 err_timeout,
    input  logic                 err_clr
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] REQ_LAST   = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_XFER, S_GAP} state_e;

    state_e        state_q, state_d;
    logic          newd_q, newd_d;
    logic [DW-1:0] din_q, din_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic [DW-1:0] req_word [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_word[g] = req_data[g*DW +: DW];
    end

    // Search starts one past the last winner and wraps, so the previous winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = rr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == REQ_LAST) ? '0 : cand + 1'b1;
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        newd_d    = newd_q;
        din_d     = din_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        err_d     = err_q;
        req_ready = '0;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    din_d   = req_word[win_idx];
                    grant_d = win_idx;
                    rr_d    = win_idx;
                    newd_d  = 1'b1;
                    timer_d = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH, S_XFER: begin
                if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                if (timer_q == TIMER_LAST) begin
                    // Abort drops the word; the error set overrides a simultaneous err_clr.
                    newd_d  = 1'b0;
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (state_q == S_LAUNCH) begin
                    if (!spi_cs) begin
                        newd_d  = 1'b0;
                        state_d = S_XFER;
                    end
                end else if (spi_cs) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset too, so spi_din reads zero until the first grant.
            state_q <= S_IDLE;
            newd_q  <= 1'b0;
            din_q   <= '0;
            grant_q <= '0;
            rr_q    <= REQ_LAST;
            timer_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            newd_q  <= newd_d;
            din_q   <= din_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign spi_newd    = newd_q;
    assign spi_din     = din_q;
    assign grant_id    = grant_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter with a small behavioural SPI master that
// shifts one bit per clk, LSB first, and can be held stuck with cs high.
module tb_spi_tx_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 12;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 64;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 spi_newd;
    logic [DW-1:0]        spi_din;
    logic                 spi_cs;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 done;
    logic                 err_timeout;
    logic                 err_clr;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Master model state.
    bit            cs_stuck;
    bit            m_active;
    int            m_bit;
    int            m_starts = 0;
    logic [DW-1:0] m_sr;
    logic          mosi;

    spi_tx_arbiter #(
        .NREQ(NREQ), .DW(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .spi_newd(spi_newd), .spi_din(spi_din), .spi_cs(spi_cs),
        .busy(busy), .grant_id(grant_id), .done(done),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Starts a frame one clk after seeing newd, drops cs, shifts 12 bits, raises cs.
    always @(posedge clk) begin
        if (rst) begin
            spi_cs   <= 1'b1;
            m_active <= 1'b0;
            m_bit    <= 0;
            mosi     <= 1'b0;
            m_sr     <= '0;
        end else if (!m_active) begin
            if (spi_newd && !cs_stuck) begin
                spi_cs   <= 1'b0;
                m_active <= 1'b1;
                m_bit    <= 0;
                m_sr     <= spi_din;
                mosi     <= spi_din[0];
                m_starts <= m_starts + 1;
            end
        end else if (m_bit == DW - 1) begin
            spi_cs   <= 1'b1;
            m_active <= 1'b0;
        end else begin
            m_bit <= m_bit + 1;
            mosi  <= m_sr[1];
            m_sr  <= m_sr >> 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic wait_accept(input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok, output int dones);
        ok    = 1'b0;
        dones = 0;
        for (int c = 0; c < bound; c++) begin
            if (done) dones++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vecs++;
        if ({busy, spi_newd, done, err_timeout} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_flags: busy/newd/done/err got %b expected 0000",
                     {busy, spi_newd, done, err_timeout});
        end
        vecs++;
        if ({spi_din, req_ready, grant_id} !== '0) begin
            errs++;
            $display("FAIL reset_regs: din=%h ready=%b grant=%0d expected all zero",
                     spi_din, req_ready, grant_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit            ok = 1'b0;
        int            nh = 0, dc = 0, ns = 0, bad_rdy = 0, bad_din = 0;
        logic [DW-1:0] bits = '0;
        req_data  = {12'h000, 12'hA5C, 12'h000, 12'h000};
        req_valid = 4'b0100;
        #1;
        vecs++;
        if (req_ready !== 4'b0100) begin
            errs++;
            $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        vecs++;
        if ({spi_newd, grant_id, busy} !== {1'b1, 2'd2, 1'b1}) begin
            errs++;
            $display("FAIL single_launch: newd/grant/busy got %b/%0d/%b expected 1/2/1",
                     spi_newd, grant_id, busy);
        end
        nh = 1;
        for (int c = 0; c < 40; c++) begin
            if (req_ready !== '0) bad_rdy++;
            if (spi_din !== 12'hA5C) bad_din++;
            step();
            if (spi_newd) nh++;
            if (done) dc++;
            if (!spi_cs) begin
                ns++;
                bits = {mosi, bits[DW-1:1]};
            end
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL single_idle: busy still high after 40 cycles");
        end
        // The master sees newd one clk after accept and drops cs the same edge, so
        // newd is visible for exactly two sampled cycles.
        vecs++;
        if (nh !== 2) begin
            errs++;
            $display("FAIL single_newd_len: got %0d cycles expected 2", nh);
        end
        vecs++;
        if (dc !== 1) begin
            errs++;
            $display("FAIL single_done: got %0d pulses expected 1", dc);
        end
        // mosi LSB first 0,0,1,1,1,0,1,0,0,1,0,1 reassembles to 12'hA5C.
        vecs++;
        if (ns !== 12 || bits !== 12'hA5C) begin
            errs++;
            $display("FAIL single_mosi: %0d bits value %h expected 12 bits value a5c", ns, bits);
        end
        vecs++;
        if (bad_rdy !== 0 || bad_din !== 0) begin
            errs++;
            $display("FAIL single_hold: ready-while-busy %0d din-changed %0d expected 0 0",
                     bad_rdy, bad_din);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int idx, bad_busy = 0, bad_hot = 0, dones;
        bit ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_data  = {12'h004, 12'h003, 12'h002, 12'h001};
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 200 && got.size() < 5; c++) begin
            if (req_ready != '0) begin
                idx = onehot_idx(req_ready);
                if (idx < 0) bad_hot++;
                if (busy) bad_busy++;
                got.push_back(idx);
                step();
                vecs++;
                if (spi_din !== 12'(idx + 1)) begin
                    errs++;
                    $display("FAIL rr_din: got %h expected %h", spi_din, 12'(idx + 1));
                end
            end else begin
                if (!busy) bad_busy++;
                step();
            end
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (k >= got.size() || got[k] !== exp_order[k]) begin
                errs++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d",
                         k, (k < got.size()) ? got[k] : -1, exp_order[k]);
            end
        end
        vecs++;
        if (bad_busy !== 0 || bad_hot !== 0) begin
            errs++;
            $display("FAIL rr_busy: busy-mismatch %0d non-onehot %0d expected 0 0",
                     bad_busy, bad_hot);
        end
        wait_idle(60, ok, dones);
    endtask

    task automatic test_back_to_back();
        int   acc = 0, rise = -1, gapd = -1, starts0, dones;
        logic prev_cs;
        bit   ok;
        req_data  = {12'h000, 12'h000, 12'h111, 12'h000};
        req_valid = 4'b0010;
        starts0   = m_starts;
        prev_cs   = spi_cs;
        #1;
        for (int c = 0; c < 120 && acc < 2; c++) begin
            if (spi_cs && !prev_cs) rise = cyc;
            prev_cs = spi_cs;
            if (req_ready[1]) begin
                if (acc == 1) gapd = cyc - rise;
                acc++;
            end
            step();
        end
        req_valid = '0;
        wait_idle(60, ok, dones);
        vecs++;
        if (acc !== 2 || !ok) begin
            errs++;
            $display("FAIL b2b_accepts: got %0d accepts idle=%b expected 2 idle=1", acc, ok);
        end
        vecs++;
        if (gapd !== GAP + 1) begin
            errs++;
            $display("FAIL b2b_gap: cs-rise to ready %0d clks expected %0d", gapd, GAP + 1);
        end
        vecs++;
        if (m_starts - starts0 !== 2) begin
            errs++;
            $display("FAIL b2b_starts: master started %0d times expected 2", m_starts - starts0);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int nh = 0, dc = 0, starts0, dones;
        cs_stuck  = 1'b1;
        starts0   = m_starts;
        req_data  = {12'h3C3, 12'h000, 12'h000, 12'h000};
        req_valid = 4'b1000;
        #1;
        wait_accept(50, ok);
        step();
        req_valid = '0;
        for (int c = 0; c < 100; c++) begin
            if (spi_newd) nh++;
            if (done) dc++;
            if (!busy) break;
            step();
        end
        vecs++;
        if (!ok || nh !== TIMEOUT) begin
            errs++;
            $display("FAIL to_newd_len: accepted=%b newd %0d cycles expected 1/%0d", ok, nh, TIMEOUT);
        end
        vecs++;
        if (err_timeout !== 1'b1 || dc !== 0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL to_abort: err=%b done=%0d busy=%b expected 1 0 0", err_timeout, dc, busy);
        end
        vecs++;
        if (m_starts !== starts0) begin
            errs++;
            $display("FAIL to_starts: master started %0d times expected 0", m_starts - starts0);
        end
        cs_stuck  = 1'b0;
        req_data  = {12'h0F0, 12'h000, 12'h000, 12'h000};
        req_valid = 4'b1000;
        #1;
        wait_accept(50, ok);
        step();
        req_valid = '0;
        wait_idle(60, ok, dones);
        vecs++;
        if (!ok || dones !== 1 || grant_id !== 2'd3 || err_timeout !== 1'b1) begin
            errs++;
            $display("FAIL to_next: idle=%b done=%0d grant=%0d err=%b expected 1 1 3 1",
                     ok, dones, grant_id, err_timeout);
        end
    endtask

    task automatic test_err_clr();
        bit ok;
        int dones;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vecs++;
        if (err_timeout !== 1'b0) begin
            errs++;
            $display("FAIL clr_pulse: err got %b expected 0", err_timeout);
        end
        cs_stuck  = 1'b1;
        req_valid = 4'b1000;
        #1;
        wait_accept(50, ok);
        step();
        req_valid = '0;
        for (int j = 0; j < TIMEOUT - 1; j++) step();
        vecs++;
        if ({spi_newd, err_timeout} !== 2'b10) begin
            errs++;
            $display("FAIL clr_pre: newd/err got %b expected 10", {spi_newd, err_timeout});
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vecs++;
        if ({spi_newd, err_timeout} !== 2'b01) begin
            errs++;
            $display("FAIL clr_set_wins: newd/err got %b expected 01", {spi_newd, err_timeout});
        end
        cs_stuck = 1'b0;
        wait_idle(20, ok, dones);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dones;
        req_data  = {12'h000, 12'h000, 12'h000, 12'h5A5};
        req_valid = 4'b0001;
        #1;
        wait_accept(50, ok);
        step();
        req_valid = '0;
        for (int c = 0; c < 30 && !(m_active && m_bit == 6); c++) step();
        vecs++;
        if (!(m_active && m_bit == 6) || busy !== 1'b1) begin
            errs++;
            $display("FAIL rm_reach: active=%b bit=%0d busy=%b expected 1 6 1", m_active, m_bit, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if ({busy, spi_newd, spi_cs} !== 3'b001) begin
            errs++;
            $display("FAIL rm_state: busy/newd/cs got %b expected 001", {busy, spi_newd, spi_cs});
        end
        req_data  = {12'h004, 12'h003, 12'h002, 12'h001};
        req_valid = 4'b1111;
        #1;
        vecs++;
        if (req_ready !== 4'b0001) begin
            errs++;
            $display("FAIL rm_rr: ready got %b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        wait_idle(60, ok, dones);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        err_clr   = 1'b0;
        cs_stuck  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_timeout();
        test_err_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
